// File: rtl/rgb_pkg.sv
// Shared state encodings, colour codes and the saturated-colour ring used by
// the RGB light sequencer.
package rgb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVR  = 2'd2
    } state_t;

    localparam logic [2:0] COL_OFF     = 3'b000;
    localparam logic [2:0] COL_BLUE    = 3'b001;
    localparam logic [2:0] COL_GREEN   = 3'b010;
    localparam logic [2:0] COL_CYAN    = 3'b011;
    localparam logic [2:0] COL_RED     = 3'b100;
    localparam logic [2:0] COL_MAGENTA = 3'b101;
    localparam logic [2:0] COL_YELLOW  = 3'b110;
    localparam logic [2:0] COL_WHITE   = 3'b111;

    // 001 -> 010 -> ... -> 110 -> 001; off/white fall back into the ring.
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        logic [2:0] n;
        case (c)
            COL_BLUE:    n = COL_GREEN;
            COL_GREEN:   n = COL_CYAN;
            COL_CYAN:    n = COL_RED;
            COL_RED:     n = COL_MAGENTA;
            COL_MAGENTA: n = COL_YELLOW;
            default:     n = COL_BLUE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rgb_light_sequencer_dwell_timer.sv
// Dwell counter: signals done in the last cycle of each dwell period; a
// programmed dwell of 0 behaves as 1.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               done
);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] last;

    assign last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
    assign done = en && !clr && (cnt == last);

    // dwell is latched on clear and at each terminal count, i.e. at the start of every step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            dwell_q <= '0;
        end else if (clr) begin
            cnt     <= '0;
            dwell_q <= dwell;
        end else if (en) begin
            if (cnt == last) begin
                cnt     <= '0;
                dwell_q <= dwell;
            end else begin
                cnt <= cnt + DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/rgb_light_sequencer.sv
// Sequences the RGB converter through the six saturated colours, with a
// single req/gnt override that forces a fixed colour.
module rgb_light_sequencer
    import rgb_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               ovr_req,
    input  logic [2:0]         ovr_colour,
    output logic               ovr_gnt,
    output logic [2:0]         colour,
    output logic               enable,
    output logic               step
);

    state_t     state, state_n;
    logic [2:0] saved, saved_n;
    logic [2:0] colour_n;
    logic       enable_n, gnt_n, step_n;
    logic       run_hold;
    logic       done;

    // Timer runs only while RUN continues; any exit or re-entry restarts it.
    assign run_hold = (state == RUN) && !ovr_req && run;

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (!run_hold),
        .en    (run_hold),
        .dwell (dwell),
        .done  (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            colour  <= COL_OFF;
            enable  <= 1'b0;
            ovr_gnt <= 1'b0;
            step    <= 1'b0;
            saved   <= COL_BLUE;
        end else begin
            state   <= state_n;
            colour  <= colour_n;
            enable  <= enable_n;
            ovr_gnt <= gnt_n;
            step    <= step_n;
            saved   <= saved_n;
        end
    end

    always_comb begin
        state_n  = state;
        colour_n = colour;
        enable_n = enable;
        gnt_n    = 1'b0;
        step_n   = 1'b0;
        saved_n  = saved;
        case (state)
            IDLE: begin
                enable_n = 1'b0;
                if (ovr_req) begin
                    state_n  = OVR;
                    gnt_n    = 1'b1;
                    enable_n = 1'b1;
                    colour_n = ovr_colour;
                end else if (run) begin
                    state_n  = RUN;
                    enable_n = 1'b1;
                    colour_n = saved;
                end
            end
            RUN: begin
                enable_n = 1'b1;
                if (ovr_req) begin
                    state_n  = OVR;
                    saved_n  = colour;
                    gnt_n    = 1'b1;
                    colour_n = ovr_colour;
                end else if (!run) begin
                    state_n  = IDLE;
                    saved_n  = colour;
                    enable_n = 1'b0;
                end else if (done) begin
                    colour_n = next_colour(colour);
                    step_n   = 1'b1;
                end
            end
            OVR: begin
                if (ovr_req) begin
                    gnt_n    = 1'b1;
                    enable_n = 1'b1;
                    colour_n = ovr_colour;
                end else if (run) begin
                    state_n  = RUN;
                    enable_n = 1'b1;
                    colour_n = saved;
                end else begin
                    state_n  = IDLE;
                    enable_n = 1'b0;
                end
            end
            default: begin
                state_n  = IDLE;
                enable_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rgb_light_sequencer.sv
// Directed self-checking bench for rgb_light_sequencer.
module tb_rgb_light_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] dwell;
    logic       ovr_req;
    logic [2:0] ovr_colour;
    logic       ovr_gnt;
    logic [2:0] colour;
    logic       enable;
    logic       step;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] ring [6];

    rgb_light_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .dwell      (dwell),
        .ovr_req    (ovr_req),
        .ovr_colour (ovr_colour),
        .ovr_gnt    (ovr_gnt),
        .colour     (colour),
        .enable     (enable),
        .step       (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] c, input logic en,
                           input logic g, input logic s);
        chk({tag, ".colour"}, {5'b0, colour}, {5'b0, c});
        chk({tag, ".enable"}, {7'b0, enable}, {7'b0, en});
        chk({tag, ".gnt"},    {7'b0, ovr_gnt}, {7'b0, g});
        chk({tag, ".step"},   {7'b0, step}, {7'b0, s});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then start running; returns just after the entry edge (colour 001, k=0).
    task automatic restart(input logic [7:0] d);
        rst = 1'b1; run = 1'b0; ovr_req = 1'b0; ovr_colour = 3'b000; dwell = d;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        tick();
    endtask

    initial begin
        ring[0] = 3'b001; ring[1] = 3'b010; ring[2] = 3'b011;
        ring[3] = 3'b100; ring[4] = 3'b101; ring[5] = 3'b110;

        // Reset state
        rst = 1'b1; run = 1'b0; ovr_req = 1'b0; ovr_colour = 3'b000; dwell = 8'd3;
        tick(); tick();
        chk_out("reset", 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_out("idle", 3'b000, 1'b0, 1'b0, 1'b0);

        // Dwell 3: full ring plus wrap back to blue
        restart(8'd3);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            chk_out($sformatf("d3_k%0d", k), ring[(k / 3) % 6], 1'b1, 1'b0,
                    (k > 0) && (k % 3 == 0));
        end

        // Dwell 0 behaves as 1: advance every cycle
        restart(8'd0);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            chk_out($sformatf("d0_k%0d", k), ring[k % 6], 1'b1, 1'b0, k > 0);
        end

        // Override in mid-dwell of cyan
        restart(8'd3);
        for (int k = 1; k <= 7; k++) tick();
        chk_out("ovr_pre", 3'b011, 1'b1, 1'b0, 1'b0);
        ovr_req = 1'b1; ovr_colour = 3'b111;
        tick();
        chk_out("ovr_gnt", 3'b111, 1'b1, 1'b1, 1'b0);
        ovr_colour = 3'b010;
        tick();
        chk_out("ovr_resample", 3'b010, 1'b1, 1'b1, 1'b0);
        ovr_req = 1'b0;
        tick();
        chk_out("ovr_rel0", 3'b011, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("ovr_rel1", 3'b011, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("ovr_rel2", 3'b011, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("ovr_rel3", 3'b100, 1'b1, 1'b0, 1'b1);

        // Override in the terminal-count cycle of red wins over the advance
        restart(8'd3);
        for (int k = 1; k <= 11; k++) tick();
        chk_out("tc_pre", 3'b100, 1'b1, 1'b0, 1'b0);
        ovr_req = 1'b1; ovr_colour = 3'b000;
        tick();
        chk_out("tc_gnt", 3'b000, 1'b1, 1'b1, 1'b0);
        ovr_req = 1'b0;
        tick();
        chk_out("tc_rel0", 3'b100, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk_out("tc_rel2", 3'b100, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("tc_rel3", 3'b101, 1'b1, 1'b0, 1'b1);

        // Pause at magenta and resume with a full dwell
        restart(8'd3);
        for (int k = 1; k <= 13; k++) tick();
        run = 1'b0;
        tick();
        chk_out("pause0", 3'b101, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("pause1", 3'b101, 1'b0, 1'b0, 1'b0);
        run = 1'b1;
        tick();
        chk_out("resume0", 3'b101, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk_out("resume2", 3'b101, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("resume3", 3'b110, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset during an override discards it and the saved colour
        restart(8'd3);
        for (int k = 1; k <= 4; k++) tick();
        ovr_req = 1'b1; ovr_colour = 3'b101;
        tick();
        chk_out("rst_ovr", 3'b101, 1'b1, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk_out("rst_async", 3'b000, 1'b0, 1'b0, 1'b0);
        ovr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_out("rst_run0", 3'b001, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk_out("rst_run2", 3'b001, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("rst_run3", 3'b010, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
